// File: rtl/detect_pkg.sv
// Shared constants for the serial pattern transmitter and the consecutive-ones detector bench.
// State encodings and default word/gap sizes; no logic.
package detect_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_GAP   = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_SHIFT = SHIFT,
      ST_GAP   = GAP
   } state_t;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Word-load and serial-output bundle of the pattern transmitter.
// The master drives start/word; the slave (transmitter) drives the serial line and status.
interface serial_pattern_tx_if #(
   parameter int WIDTH = 8,
   parameter int CNTW  = $clog2(WIDTH) + 1
);
   logic             start;
   logic [WIDTH-1:0] word;
   logic             dout;
   logic             dout_valid;
   logic             busy;
   logic             done;
   logic [CNTW-1:0]  pair_cnt;

   modport master (
      output start, word,
      input  dout, dout_valid, busy, done, pair_cnt
   );

   modport slave (
      input  start, word,
      output dout, dout_valid, busy, done, pair_cnt
   );
endinterface

// File: rtl/serial_pattern_tx.sv
// Shifts a captured word out MSB-first one bit per clock, then GAP zero cycles, then a done pulse.
// First bit appears the cycle after start is accepted; start is ignored (not stalled) while busy.
module serial_pattern_tx #(
   parameter int WIDTH = detect_pkg::DEF_WIDTH,
   parameter int GAP   = detect_pkg::DEF_GAP
) (
   input  logic               ck,
   input  logic               rst,
   serial_pattern_tx_if.slave bus
);
   import detect_pkg::*;

   localparam int CNTW = $clog2(WIDTH) + 1;
   localparam int BW   = $clog2(WIDTH);
   localparam int GW   = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

   state_t           r_state;
   logic [WIDTH-1:0] r_sh;
   logic [BW-1:0]    r_bit;
   logic [GW-1:0]    r_gap;
   logic             r_dout;
   logic             r_vld;
   logic             r_busy;
   logic             r_done;
   logic [CNTW-1:0]  r_pair;

   // r_sh[WIDTH-1] always holds the bit currently on dout, so the next bit is r_sh[WIDTH-2]
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_sh    <= '0;
         r_bit   <= '0;
         r_gap   <= '0;
         r_dout  <= 1'b0;
         r_vld   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pair  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_sh    <= bus.word;
                  r_dout  <= bus.word[WIDTH-1];
                  r_vld   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_pair  <= '0;
                  r_bit   <= '0;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (r_bit == BIT_LAST) begin
                  r_dout <= 1'b0;
                  r_vld  <= 1'b0;
                  r_gap  <= '0;
                  if (GAP > 0) begin
                     r_state <= ST_GAP;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end else begin
                  r_sh   <= {r_sh[WIDTH-2:0], 1'b0};
                  r_dout <= r_sh[WIDTH-2];
                  r_bit  <= r_bit + 1'b1;
                  if (r_sh[WIDTH-1] && r_sh[WIDTH-2]) begin
                     r_pair <= r_pair + 1'b1;
                  end
               end
            end
            ST_GAP: begin
               if (r_gap == GAP_LAST) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_gap <= r_gap + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_dout  <= 1'b0;
               r_vld   <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dout       = r_dout;
   assign bus.dout_valid = r_vld;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.pair_cnt   = r_pair;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: a GAP=1 and a GAP=0 instance, scoreboard of expected bits and pair counts.
module tb_serial_pattern_tx;

   logic ck = 1'b0;
   logic rst;
   always #5 ck = ~ck;

   serial_pattern_tx_if #(.WIDTH(8), .CNTW(4)) if_g1 ();
   serial_pattern_tx_if #(.WIDTH(8), .CNTW(4)) if_g0 ();

   serial_pattern_tx #(.WIDTH(8), .GAP(1)) u_g1 (.ck(ck), .rst(rst), .bus(if_g1));
   serial_pattern_tx #(.WIDTH(8), .GAP(0)) u_g0 (.ck(ck), .rst(rst), .bus(if_g0));

   int tests = 0;
   int fails = 0;

   logic sel;
   logic m_dout, m_valid, m_busy, m_done;
   logic [3:0] m_pair;
   int m_gap;
   assign m_dout  = sel ? if_g0.dout       : if_g1.dout;
   assign m_valid = sel ? if_g0.dout_valid : if_g1.dout_valid;
   assign m_busy  = sel ? if_g0.busy       : if_g1.busy;
   assign m_done  = sel ? if_g0.done       : if_g1.done;
   assign m_pair  = sel ? if_g0.pair_cnt   : if_g1.pair_cnt;
   assign m_gap   = sel ? 0 : 1;

   logic exp_bits[$];
   int   exp_pair[$];

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   function automatic int pairs_of(logic [7:0] w);
      int n = 0;
      for (int i = 0; i < 7; i++) if (w[i] && w[i+1]) n++;
      return n;
   endfunction

   task automatic set_start(logic s, logic [7:0] w);
      if (sel) begin
         if_g0.start = s;
         if_g0.word  = w;
      end else begin
         if_g1.start = s;
         if_g1.word  = w;
      end
   endtask

   task automatic push_word(logic [7:0] w);
      for (int i = 7; i >= 0; i--) exp_bits.push_back(w[i]);
      exp_pair.push_back(pairs_of(w));
   endtask

   task automatic send(logic [7:0] w);
      set_start(1'b1, w);
      push_word(w);
      step();
      set_start(1'b0, w);
   endtask

   task automatic check_idle(string name);
      tests++;
      if ({m_valid, m_dout, m_busy, m_done} !== 4'b0000) begin
         fails++;
         $display("FAIL %s: valid/dout/busy/done=%b required 0000", name, {m_valid, m_dout, m_busy, m_done});
      end
   endtask

   // Entered on the cycle carrying the MSB; leaves on the done cycle without stepping past it.
   task automatic expect_word(string name, int glitch_at, logic [7:0] glitch_w);
      int   seen = 0;
      logic prev = 1'b0;
      logic eb;
      int   ep;
      for (int i = 0; i < 8; i++) begin
         if (exp_bits.size() > 0) eb = exp_bits.pop_front();
         else eb = 1'bx;
         tests++;
         if ({m_valid, m_dout, m_busy, m_done} !== {1'b1, eb, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL %s bit%0d: valid/dout/busy/done=%b required %b", name, i,
                     {m_valid, m_dout, m_busy, m_done}, {1'b1, eb, 1'b1, 1'b0});
         end
         if (prev && m_dout) seen++;
         prev = m_dout;
         if (i == glitch_at) begin
            set_start(1'b1, glitch_w);
            step();
            set_start(1'b0, glitch_w);
         end else begin
            step();
         end
      end
      for (int g = 0; g < m_gap; g++) begin
         tests++;
         if ({m_valid, m_dout, m_busy, m_done} !== 4'b0010) begin
            fails++;
            $display("FAIL %s gap%0d: valid/dout/busy/done=%b required 0010", name, g,
                     {m_valid, m_dout, m_busy, m_done});
         end
         step();
      end
      ep = (exp_pair.size() > 0) ? exp_pair.pop_front() : -1;
      tests++;
      if ({m_valid, m_busy, m_done} !== 3'b001) begin
         fails++;
         $display("FAIL %s done: valid/busy/done=%b required 001", name, {m_valid, m_busy, m_done});
      end
      tests++;
      if (int'(m_pair) !== ep) begin
         fails++;
         $display("FAIL %s pair_cnt: got %0d required %0d", name, m_pair, ep);
      end
      tests++;
      if (seen !== ep) begin
         fails++;
         $display("FAIL %s detector hits: got %0d required %0d", name, seen, ep);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      sel = 1'b0;
      if_g1.start = 1'b0; if_g1.word = '0;
      if_g0.start = 1'b0; if_g0.word = '0;
      step();
      step();
      tests++;
      if ({if_g1.dout, if_g1.dout_valid, if_g1.busy, if_g1.done, if_g1.pair_cnt} !== 8'h00) begin
         fails++;
         $display("FAIL reset_g1: outputs=%b required 0", {if_g1.dout, if_g1.dout_valid, if_g1.busy, if_g1.done, if_g1.pair_cnt});
      end
      tests++;
      if ({if_g0.dout, if_g0.dout_valid, if_g0.busy, if_g0.done, if_g0.pair_cnt} !== 8'h00) begin
         fails++;
         $display("FAIL reset_g0: outputs=%b required 0", {if_g0.dout, if_g0.dout_valid, if_g0.busy, if_g0.done, if_g0.pair_cnt});
      end
      rst = 1'b1;
      step();
      check_idle("reset_release");
   endtask

   task automatic test_basic();
      sel = 1'b0;
      send(8'b1011_1001);
      expect_word("basic_b9", -1, 8'h00);
      step();
      check_idle("basic_done_one_cycle");
   endtask

   task automatic test_patterns();
      sel = 1'b0;
      send(8'hFF);
      expect_word("pat_ff", -1, 8'h00);
      step();
      send(8'h55);
      expect_word("pat_55", -1, 8'h00);
      step();
      check_idle("pat_idle");
   endtask

   task automatic test_start_while_busy();
      sel = 1'b0;
      send(8'hF0);
      expect_word("busy_f0", 3, 8'h0F);
      for (int i = 0; i < 3; i++) begin
         step();
         check_idle("busy_no_second_word");
      end
   endtask

   task automatic test_back_to_back();
      sel = 1'b0;
      set_start(1'b1, 8'hA5);
      push_word(8'hA5);
      step();
      set_start(1'b1, 8'h3C);
      push_word(8'h3C);
      expect_word("b2b_a5", -1, 8'h00);
      step();
      set_start(1'b0, 8'h3C);
      expect_word("b2b_3c", -1, 8'h00);
      step();
      check_idle("b2b_idle");
   endtask

   task automatic test_async_reset();
      sel = 1'b0;
      send(8'hFF);
      for (int i = 0; i < 4; i++) step();
      #2;
      rst = 1'b0;
      #1;
      tests++;
      if ({m_dout, m_valid, m_busy, m_done, m_pair} !== 8'h00) begin
         fails++;
         $display("FAIL async_reset: dout/valid/busy/done/pair=%b required 0", {m_dout, m_valid, m_busy, m_done, m_pair});
      end
      exp_bits.delete();
      exp_pair.delete();
      step();
      step();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_idle("async_no_done");
      end
      send(8'h3C);
      expect_word("async_after_3c", -1, 8'h00);
      step();
   endtask

   task automatic test_gap0();
      sel = 1'b1;
      send(8'b1100_0011);
      expect_word("gap0_c3", -1, 8'h00);
      step();
      check_idle("gap0_idle");
      set_start(1'b1, 8'hC3);
      push_word(8'hC3);
      push_word(8'hC3);
      step();
      expect_word("gap0_held_a", -1, 8'h00);
      step();
      set_start(1'b0, 8'hC3);
      expect_word("gap0_held_b", -1, 8'h00);
      step();
      check_idle("gap0_held_idle");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_patterns();
      test_start_while_busy();
      test_back_to_back();
      test_async_reset();
      test_gap0();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Transmitter end of the serial bit-stream interface consumed by the consecutive-ones detector.
- Accepts a parallel word on a start strobe and shifts it out MSB-first, one bit per clock, on a single serial line.
- Follows each word with a configurable run of zero gap bits.
- Also reports how many adjacent 1-1 pairs it emitted within the word, giving the bench an expected detector hit count.

Parameters:
- WIDTH, 8, bits per word; must be >= 2.
- GAP, 1, number of zero cycles appended after each word; 0 allowed.
- CNTW, $clog2(WIDTH)+1, width of pair_cnt; derived, not overridden.

Ports:
- ck  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 forces reset immediately.
- start  input  1  load request; sampled only in IDLE.
- word  input  WIDTH  parallel data, captured on the edge that accepts start.
- dout  output  1  serial data; the detector's din connects here.
- dout_valid  output  1  high while dout carries a word bit; low in IDLE and GAP.
- busy  output  1  high in SHIFT and GAP.
- done  output  1  one-cycle pulse after the word and its gap complete.
- pair_cnt  output  CNTW  count of emitted bit pairs (b[i], b[i+1]) that are both 1 in the current or last word.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, dout=0, dout_valid=0, busy=0, done=0, pair_cnt=0, shift register=0, bit counter=0. Reset applied mid-word aborts the word with no done pulse. After rst returns to 1, the next start is accepted normally.
- All outputs are registered. No combinational path from start or word to any output.
- States: IDLE, SHIFT, GAP.
- IDLE -> SHIFT: on an edge where start=1.
  - Captures word.
  - dout <= word[WIDTH-1], dout_valid <= 1, busy <= 1, pair_cnt <= 0, bit counter <= 0.
- SHIFT: each edge advances to the next bit, MSB to LSB.
  - If start accepted at edge k, bit i (i=0 is the MSB) is on dout during the cycle after edge k+i.
  - After the LSB cycle (edge k+WIDTH): if GAP>0, go to GAP; otherwise go to IDLE.
- GAP: dout=0, dout_valid=0, busy=1 for exactly GAP cycles, then IDLE.
- done: high for exactly one cycle after edge k+WIDTH+GAP, coinciding with busy=0 and state IDLE.
- pair_cnt:
  - Increments by 1 on each edge that presents bit i+1 (i+1 <= WIDTH-1) when bit i and bit i+1 are both 1.
  - Never counts across word boundaries or gap bits.
  - Holds its final value until the next accepted start.
  - Maximum value is WIDTH-1, so no wrap is possible.
- start while busy=1: ignored, with no effect on data, counters or outputs.
- start during the done cycle: accepted, since the state is IDLE. First bit appears next cycle, giving back-to-back words separated only by the gap.
- word changes after capture: no effect on the word in flight.

Decomposition:
- Shared package (detect_pkg):
  - State encoding localparams IDLE=2'd0, SHIFT=2'd1, GAP=2'd2.
  - Default WIDTH/GAP constants, also used by the detector bench.
- Single flat module: shift register, bit counter, gap counter and pair counter.
- No sub-module is natural at this size.

Test Plan:
1. WIDTH=8, GAP=1, rst pulse low then high, start with word=8'b1011_1001.
   - dout sequence 1,0,1,1,1,0,0,1 with dout_valid=1, then one 0 with dout_valid=0.
   - done pulse 9 cycles after acceptance; pair_cnt=2.
   - Detector chained on dout asserts exactly twice.
2. word=8'hFF → eight 1s, pair_cnt=7. Then word=8'h55 → alternating bits, pair_cnt=0.
3. Accept word=8'hF0, then pulse start with word=8'h0F at bit 3.
   - Second start is ignored: full F0 stream and one done pulse.
   - pair_cnt=3; busy stays high throughout.
4. Hold start=1 continuously with GAP=1, words A then B.
   - B accepted on A's done cycle.
   - B's MSB appears the cycle after done; exactly one gap zero separates the words.
5. Drive rst=0 asynchronously mid-SHIFT (between edges) after bit 4.
   - dout, dout_valid, busy and pair_cnt go to 0 immediately; no done pulse.
   - Next start streams correctly.
6. GAP=0 build, word=8'b1100_0011.
   - 8 valid bits; done the cycle after the LSB; pair_cnt=2.
   - A held start re-launches the same word with no idle bit.
